// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD card-side CMD line responder.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_WAIT_NCR,
        ST_SEND
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_R1,
        RESP_R2,
        RESP_R3
    } resp_t;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int CMD_LEN = 48;
    localparam int R2_LEN  = 136;

    // Bit positions (counted from the response start bit) of the CRC-covered
    // region and of the CRC field itself.
    localparam int R1_CRC_POS  = 40;
    localparam int R2_DATA_POS = 8;
    localparam int R2_CRC_POS  = 128;

    // Response format owed for an accepted command index.
    function automatic resp_t resp_sel(input logic [5:0] idx);
        resp_t r;
        case (idx)
            6'd0:               r = RESP_NONE;
            6'd2, 6'd9, 6'd10:  r = RESP_R2;
            6'd41:              r = RESP_R3;
            default:            r = RESP_R1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sd_card_cmd_responder_if.sv
// CMD line bundle between an SD host and the card-side responder.
interface sd_card_cmd_responder_if;
    logic cmd_pin_in;
    logic cmd_pin_out;
    logic cmd_pin_oe;

    modport master (
        output cmd_pin_in,
        input  cmd_pin_out,
        input  cmd_pin_oe
    );

    modport slave (
        input  cmd_pin_in,
        output cmd_pin_out,
        output cmd_pin_oe
    );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, shared by receive and transmit paths.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;
    assign fb = bit_in ^ crc[6];

    // Clear has priority so the owner can restart the CRC on any cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc <= 7'h00;
        end else if (clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit command frames, checks framing
// and CRC7, reports the command and serialises the R1/R2/R3 response.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | line released, waiting for a start bit (0)
// ST_RECV     | shifting in the remaining 47 frame bits
// ST_CHECK    | one cycle: validate frame, latch command, load response
// ST_WAIT_NCR | line released for NCR cycles before the response
// ST_SEND     | driving the response, then one release cycle
module sd_card_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int NCR = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    sd_card_cmd_responder_if.slave        cmd_bus,
    input  logic [31:0]                   card_status,
    input  logic [31:0]                   ocr,
    input  logic [119:0]                  cid_csd,
    output logic                          cmd_valid,
    output logic [5:0]                    cmd_index,
    output logic [31:0]                   cmd_arg,
    output logic                          crc_err,
    output logic                          busy
);

    // WAIT_NCR counts down from NCR-1; the terminal-count cycle hands over to
    // SEND, whose first edge drives the start bit.
    localparam logic [5:0] NCR_LOAD = 6'(NCR - 1);

    state_t       state;
    resp_t        resp_type;
    logic [135:0] shreg;
    logic [7:0]   bit_cnt;
    logic [5:0]   ncr_cnt;
    logic         line_out;
    logic         line_oe;

    logic         crc_clr;
    logic         crc_en;
    logic         crc_din;
    logic [6:0]   crc_val;

    logic [5:0]   rx_index;
    logic [31:0]  rx_arg;
    logic         frame_ok;
    resp_t        rx_resp;

    logic [7:0]   resp_len;
    logic [7:0]   crc_start;
    logic [7:0]   crc_off;
    logic         in_crc;
    logic         tx_bit;

    assign cmd_bus.cmd_pin_out = line_out;
    assign cmd_bus.cmd_pin_oe  = line_oe;

    // After the 48th bit the whole frame sits in shreg[47:0].
    assign rx_index = shreg[45:40];
    assign rx_arg   = shreg[39:8];
    assign frame_ok = shreg[46] && shreg[0] && (shreg[7:1] == crc_val);
    assign rx_resp  = resp_sel(rx_index);

    sd_crc7 u_crc (
        .clock  (clock),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_din),
        .crc    (crc_val)
    );

    // CRC engine steering: receive covers frame bits 1..39 (bit 0 is a zero
    // into a cleared register), transmit covers the response data region.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_din = 1'b0;
        case (state)
            ST_IDLE:  crc_clr = 1'b1;
            ST_RECV: begin
                crc_din = cmd_bus.cmd_pin_in;
                crc_en  = (bit_cnt < 8'(R1_CRC_POS));
            end
            ST_CHECK: crc_clr = 1'b1;
            ST_SEND: begin
                crc_din = shreg[135];
                crc_en  = ((resp_type == RESP_R1) && (bit_cnt < 8'(R1_CRC_POS))) ||
                          ((resp_type == RESP_R2) && (bit_cnt >= 8'(R2_DATA_POS)) &&
                           (bit_cnt < 8'(R2_CRC_POS)));
            end
            default: ;
        endcase
    end

    // Transmit bit selection: the CRC field is taken from the engine, every
    // other bit (including the fixed R3 CRC and the end bit) from shreg.
    always_comb begin
        resp_len  = (resp_type == RESP_R2) ? 8'(R2_LEN) : 8'(CMD_LEN);
        crc_start = (resp_type == RESP_R2) ? 8'(R2_CRC_POS) : 8'(R1_CRC_POS);
        crc_off   = bit_cnt - crc_start;
        in_crc    = ((resp_type == RESP_R1) || (resp_type == RESP_R2)) &&
                    (bit_cnt >= crc_start) && (bit_cnt < (crc_start + 8'd7));
        tx_bit    = in_crc ? crc_val[3'd6 - crc_off[2:0]] : shreg[135];
    end

    // Main sequencer with registered line and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            resp_type <= RESP_NONE;
            shreg     <= '0;
            bit_cnt   <= 8'd0;
            ncr_cnt   <= 6'd0;
            line_out  <= 1'b1;
            line_oe   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_index <= 6'd0;
            cmd_arg   <= 32'd0;
            crc_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            crc_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    line_out <= 1'b1;
                    line_oe  <= 1'b0;
                    if (!cmd_bus.cmd_pin_in) begin
                        state   <= ST_RECV;
                        busy    <= 1'b1;
                        shreg   <= {shreg[134:0], 1'b0};
                        bit_cnt <= 8'd1;
                    end
                end

                ST_RECV: begin
                    shreg <= {shreg[134:0], cmd_bus.cmd_pin_in};
                    if (bit_cnt == 8'(CMD_LEN - 1)) begin
                        state <= ST_CHECK;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end

                ST_CHECK: begin
                    if (frame_ok) begin
                        cmd_valid <= 1'b1;
                        cmd_index <= rx_index;
                        cmd_arg   <= rx_arg;
                        resp_type <= rx_resp;
                        bit_cnt   <= 8'd0;
                        ncr_cnt   <= NCR_LOAD;
                        case (rx_resp)
                            RESP_R1: shreg <= {2'b00, rx_index, card_status, 7'h00, 1'b1, 88'h0};
                            RESP_R2: shreg <= {2'b00, 6'h3F, cid_csd, 7'h00, 1'b1};
                            RESP_R3: shreg <= {2'b00, 6'h3F, ocr, 7'h7F, 1'b1, 88'h0};
                            default: ;
                        endcase
                        if (rx_resp == RESP_NONE) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_WAIT_NCR;
                        end
                    end else begin
                        crc_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                ST_WAIT_NCR: begin
                    if (ncr_cnt == 6'd0) begin
                        state <= ST_SEND;
                    end else begin
                        ncr_cnt <= ncr_cnt - 6'd1;
                    end
                end

                ST_SEND: begin
                    if (bit_cnt == resp_len) begin
                        line_out <= 1'b1;
                        line_oe  <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        line_out <= tx_bit;
                        line_oe  <= 1'b1;
                        shreg    <= {shreg[134:0], 1'b0};
                        bit_cnt  <= bit_cnt + 8'd1;
                        if (bit_cnt == resp_len - 8'd1) begin
                            busy <= 1'b0;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Table-driven bench for sd_card_cmd_responder plus a reset-during-send sequence.
module tb_sd_card_cmd_responder;

    localparam int NCR  = 2;
    localparam int NVEC = 10;

    typedef struct {
        logic [47:0]  frame;
        logic [31:0]  status;
        logic [31:0]  ocr;
        logic [119:0] cid;
        logic         exp_valid;
        logic         exp_err;
        logic [5:0]   exp_index;
        logic [31:0]  exp_arg;
        int           exp_len;
        logic [135:0] exp_resp;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  card_status;
    logic [31:0]  ocr;
    logic [119:0] cid_csd;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         crc_err;
    logic         busy;

    sd_card_cmd_responder_if cmd_bus ();

    sd_card_cmd_responder #(.NCR(NCR)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_bus     (cmd_bus),
        .card_status (card_status),
        .ocr         (ocr),
        .cid_csd     (cid_csd),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .crc_err     (crc_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    vec_t vecs [NVEC];
    int   n_vec   = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    int   cur_vec = -1;

    function automatic logic [6:0] crc7_model(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] cmdf(input logic [1:0] hdr, input logic [5:0] idx,
                                         input logic [31:0] arg);
        logic [39:0] d;
        d = {hdr, idx, arg};
        return {d, crc7_model({80'h0, d}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] r1(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] d;
        d = {2'b00, idx, st};
        return {88'h0, d, crc7_model({80'h0, d}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] r2(input logic [119:0] cid);
        return {2'b00, 6'h3F, cid, crc7_model(cid, 120), 1'b1};
    endfunction

    function automatic logic [135:0] r3(input logic [31:0] o);
        return {88'h0, 2'b00, 6'h3F, o, 7'h7F, 1'b1};
    endfunction

    function automatic vec_t mkv(input logic [47:0] f, input logic [31:0] st,
                                 input logic [31:0] o, input logic [119:0] cid,
                                 input logic v, input logic e, input logic [5:0] idx,
                                 input logic [31:0] arg, input int len,
                                 input logic [135:0] resp);
        vec_t x;
        x.frame = f;   x.status = st;   x.ocr = o;   x.cid = cid;
        x.exp_valid = v;   x.exp_err = e;   x.exp_index = idx;   x.exp_arg = arg;
        x.exp_len = len;   x.exp_resp = resp;
        return x;
    endfunction

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, cur_vec, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives all 48 bits; returns just after the end-bit edge (k+47).
    task automatic drive_frame(input logic [47:0] f, output logic busy_mid);
        busy_mid = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            cmd_bus.cmd_pin_in = f[i];
            tick();
            if (i == 27) busy_mid = busy;
        end
        cmd_bus.cmd_pin_in = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic         busy_mid;
        logic         early_oe;
        logic         busy_last;
        logic [135:0] got;
        int           n;
        card_status = v.status;
        ocr         = v.ocr;
        cid_csd     = v.cid;
        drive_frame(v.frame, busy_mid);
        chk("busy_recv", 136'(busy_mid), 136'(1'b1));
        tick();
        chk("cmd_valid", 136'(cmd_valid), 136'(v.exp_valid));
        chk("crc_err", 136'(crc_err), 136'(v.exp_err));
        chk("cmd_index", 136'(cmd_index), 136'(v.exp_index));
        chk("cmd_arg", 136'(cmd_arg), 136'(v.exp_arg));
        chk("busy_check", 136'(busy), 136'(v.exp_len != 0));
        early_oe = 1'b0;
        for (int i = 0; i < NCR; i++) begin
            tick();
            if (i == 0) chk("pulse_width", 136'({cmd_valid, crc_err}), 136'(2'b00));
            if (cmd_bus.cmd_pin_oe) early_oe = 1'b1;
        end
        if (v.exp_len == 0) begin
            for (int i = 0; i < 150; i++) begin
                tick();
                if (cmd_bus.cmd_pin_oe) early_oe = 1'b1;
            end
            chk("oe_never", 136'(early_oe), 136'(1'b0));
        end else begin
            chk("ncr_release", 136'(early_oe), 136'(1'b0));
            got       = '0;
            n         = 0;
            busy_last = 1'b1;
            for (int i = 0; i < 140; i++) begin
                tick();
                if (!cmd_bus.cmd_pin_oe) break;
                got       = {got[134:0], cmd_bus.cmd_pin_out};
                busy_last = busy;
                n++;
            end
            chk("resp_len", 136'(n), 136'(v.exp_len));
            chk("resp_bits", got, v.exp_resp);
            chk("busy_last_oe", 136'(busy_last), 136'(1'b0));
            chk("release_out", 136'({cmd_bus.cmd_pin_out, cmd_bus.cmd_pin_oe}), 136'(2'b10));
        end
        n_vec++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic busy_mid;
        vec_t rv;
        cmd_bus.cmd_pin_in = 1'b1;
        card_status = '0;
        ocr         = '0;
        cid_csd     = '0;

        vecs[0] = mkv(48'h40_0000_0000_95, 32'h0, 32'h0, 120'h0,
                      1'b1, 1'b0, 6'd0, 32'h0, 0, '0);
        vecs[1] = mkv(48'h48_0000_01AA_87, 32'h0000_0120, 32'h0, 120'h0,
                      1'b1, 1'b0, 6'd8, 32'h1AA, 48, r1(6'd8, 32'h0000_0120));
        vecs[2] = mkv(48'h48_0000_01AA_86, 32'h0000_0120, 32'h0, 120'h0,
                      1'b0, 1'b1, 6'd8, 32'h1AA, 0, '0);
        vecs[3] = mkv(48'h42_0000_0000_4D, 32'h0, 32'h0, 120'h1,
                      1'b1, 1'b0, 6'd2, 32'h0, 136, r2(120'h1));
        vecs[4] = mkv(cmdf(2'b01, 6'd41, 32'h40FF_8000), 32'h0, 32'h80FF_8000, 120'h0,
                      1'b1, 1'b0, 6'd41, 32'h40FF_8000, 48, r3(32'h80FF_8000));
        vecs[5] = mkv(cmdf(2'b01, 6'd17, 32'h1234_5678), 32'hDEAD_BEEF, 32'h0, 120'h0,
                      1'b1, 1'b0, 6'd17, 32'h1234_5678, 48, r1(6'd17, 32'hDEAD_BEEF));
        vecs[6] = mkv(cmdf(2'b00, 6'd8, 32'h0000_01AA), 32'h0, 32'h0, 120'h0,
                      1'b0, 1'b1, 6'd17, 32'h1234_5678, 0, '0);
        vecs[7] = mkv(48'h40_0000_0000_94, 32'h0, 32'h0, 120'h0,
                      1'b0, 1'b1, 6'd17, 32'h1234_5678, 0, '0);
        vecs[8] = mkv(cmdf(2'b01, 6'd9, 32'hABCD_0000), 32'h0, 32'h0,
                      120'hF0E1D2C3B4A5968778695A4B3C2D1E,
                      1'b1, 1'b0, 6'd9, 32'hABCD_0000, 136,
                      r2(120'hF0E1D2C3B4A5968778695A4B3C2D1E));
        vecs[9] = mkv(cmdf(2'b01, 6'd55, 32'hFFFF_0000), 32'h0000_0000, 32'h0, 120'h0,
                      1'b1, 1'b0, 6'd55, 32'hFFFF_0000, 48, r1(6'd55, 32'h0));

        repeat (3) @(posedge clock);
        #1;
        chk("rst_out", 136'(cmd_bus.cmd_pin_out), 136'(1'b1));
        chk("rst_oe", 136'(cmd_bus.cmd_pin_oe), 136'(1'b0));
        chk("rst_valid", 136'(cmd_valid), 136'(1'b0));
        chk("rst_index", 136'(cmd_index), 136'(6'd0));
        chk("rst_arg", 136'(cmd_arg), 136'(32'd0));
        chk("rst_err", 136'(crc_err), 136'(1'b0));
        chk("rst_busy", 136'(busy), 136'(1'b0));
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < NVEC; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // Reset asserted while the CMD8 response is on bit 20.
        cur_vec = 100;
        rv = vecs[1];
        card_status = rv.status;
        drive_frame(rv.frame, busy_mid);
        tick();
        chk("rs_accept", 136'(cmd_valid), 136'(1'b1));
        repeat (NCR + 21) tick();
        chk("rs_oe_bit20", 136'(cmd_bus.cmd_pin_oe), 136'(1'b1));
        chk("rs_out_bit20", 136'(cmd_bus.cmd_pin_out), 136'(rv.exp_resp[27]));
        reset = 1'b0;
        #1;
        chk("rs_oe_drop", 136'(cmd_bus.cmd_pin_oe), 136'(1'b0));
        chk("rs_out_high", 136'(cmd_bus.cmd_pin_out), 136'(1'b1));
        chk("rs_busy", 136'(busy), 136'(1'b0));
        chk("rs_index", 136'(cmd_index), 136'(6'd0));
        n_vec++;
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        cur_vec = 101;
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_card_cmd_responder.md
# sd_card_cmd_responder

Card-side endpoint of the SD CMD line: deserialises 48-bit command frames driven by the SDHOST `cmd_pin_out`, checks framing and CRC7, reports the decoded command, and serialises the matching response back onto the host's `cmd_pin_in`. It is the counterpart of the SDHOST command path. It serves as a synthesizable card model in system benches and as the command front end of a future card-emulation top.

## Interface
- NCR, default 2: idle cycles between the command end bit and the response start bit (legal range 2..64).
- clock  input  1  SD bus clock; all sampling and driving on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_pin_in  input  1  CMD line from host; idles high.
- cmd_pin_out  output  1  CMD line value driven by the card.
- cmd_pin_oe  output  1  high while the card owns the CMD line.
- card_status  input  32  R1 payload; sampled at the CHECK cycle.
- ocr  input  32  R3 payload; sampled at the CHECK cycle.
- cid_csd  input  120  R2 payload (CID/CSD bits [127:8]); sampled at the CHECK cycle.
- cmd_valid  output  1  one-cycle pulse when a frame is accepted.
- cmd_index  output  6  index of the last accepted command.
- cmd_arg  output  32  argument of the last accepted command.
- crc_err  output  1  one-cycle pulse when a frame fails CRC or framing.
- busy  output  1  high from the start bit until the response end bit, or until the drop.

## Operation
- Command frame, MSB first: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
- CRC7 polynomial: x^7+x^3+1, initial value 0, computed over the first 40 bits.
- States:
  - IDLE: a 0 sampled on cmd_pin_in goes to RECV.
  - RECV: shifts 47 further bits; after the 48th bit, goes to CHECK.
  - CHECK: one cycle. Accepts the frame if the transmission bit is 1, the CRC matches and the end bit is 1. Accept: pulse cmd_valid, update cmd_index and cmd_arg. Otherwise: pulse crc_err, return to IDLE.
- Response selection after accept:
  - Index 0: no response; go to IDLE.
  - Indices 2, 9, 10: R2.
  - Index 41: R3.
  - All other indices: R1.
- WAIT_NCR: holds the line released, then enters SEND.
- SEND: drives 48 bits (R1, R3) or 136 bits (R2), then returns to IDLE.
- R1 layout: 0, 0, cmd_index, card_status, CRC7 over the preceding 40 bits, 1.
- R3 layout: 0, 0, 6'b111111, ocr, 7'b1111111, 1.
- R2 layout: 0, 0, 6'b111111, cid_csd[119:0], CRC7 over those 120 bits, 1.
- cmd_pin_in is ignored from CHECK through the end of SEND; no command pipelining.

## Timing
- Reset values: cmd_pin_out=1, cmd_pin_oe=0, cmd_valid=0, cmd_index=0, cmd_arg=0, crc_err=0, busy=0, state IDLE.
- Reset mid-operation: the line is released immediately and the partial frame is discarded.
- The start bit is sampled at edge k. The end bit is sampled at k+47, and CHECK (cmd_valid/crc_err) occurs at k+48.
- Line release window: oe stays 0 for NCR cycles after CHECK. The response start bit is driven from edge k+49+NCR.
- While SEND is active, oe=1 for exactly 48 or 136 consecutive cycles. After the end bit, oe=0 and out=1 on the next edge.
- busy rises with the start-bit sample. It falls with the last oe cycle, or with CHECK on reject or CMD0.
- A 0 on cmd_pin_in in the cycle after a response is treated as a new start bit.

## Structure
- Package sd_cmd_pkg holds:
  - the state enum;
  - the response-type enum (NONE, R1, R2, R3);
  - CRC7_POLY = 7'h09;
  - CMD_LEN = 48, R2_LEN = 136.
- Sub-module sd_crc7: serial CRC7 with clear, enable and bit inputs and a 7-bit output. One instance is reused for receive and for transmit.
- A single 136-bit shift register and an 8-bit bit counter serve both directions. The NCR counter is 6-bit.

## Test plan
- CMD0 frame 0x40_00000000_95 -> cmd_valid at k+48 with index 0 and arg 0; cmd_pin_oe never rises; busy falls at CHECK.
- CMD8 frame 0x48_000001AA_87 with card_status=0x00000120 -> cmd_index=8 and cmd_arg=0x1AA. With NCR=2, start bit at k+51, then 48 driven bits: 00, 001000, 0x00000120, CRC7 equal to the bench model, end bit 1.
- CMD8 with last byte 0x86 (bad CRC) -> crc_err pulse at k+48; no cmd_valid; cmd_index/cmd_arg keep their previous values; oe stays 0.
- CMD2 (0x42_00000000_4D) with cid_csd=120'h1 -> 136-bit response: 00, 111111, cid_csd, CRC7 of cid_csd, 1. oe high exactly 136 cycles.
- CMD41 arg 0x40FF8000 -> R3: 00, 111111, ocr=0x80FF8000, 1111111, 1.
- Reset pulled low during SEND at bit 20 -> same-cycle oe=0 and out=1. After release, a following CMD0 is accepted normally.
